// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Fixed N-cycle latency; divide-by-zero yields all-ones quotient.
module seq_div #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a2,
  input  logic [N-1:0] b2,
  output logic [N-1:0] quo,
  output logic [N-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] cnt;
  logic [N-1:0]  r;
  logic [N-1:0]  d;
  logic [N-1:0]  dv;
  logic [N:0]    shifted;
  logic          neg;
  logic [N-1:0]  r_nxt;
  logic [N-1:0]  d_nxt;
  logic          last;
  logic          accept;

  // Low N bits of the difference are exact whenever it is non-negative.
  always_comb begin
    shifted = {r, d[N-1]};
    neg     = ({1'b0, dv} > shifted);
    r_nxt   = neg ? shifted[N-1:0]
                  : (shifted[N-1:0] - dv);
    d_nxt   = {d[N-2:0], ~neg};
    last    = (cnt == CW'(N - 1));
    accept  = (state == IDLE) && start;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      r        <= '0;
      d        <= '0;
      dv       <= '0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        d   <= a2;
        dv  <= b2;
        r   <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        r   <= r_nxt;
        d   <= d_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          quo      <= d_nxt;
          rem      <= r_nxt;
          div_zero <= (dv == '0);
          done     <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed corner cases plus random operands
// checked against plain integer division.
module tb_seq_div;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a2;
  logic [N-1:0] b2;
  logic [N-1:0] quo;
  logic [N-1:0] rem;
  logic         busy;
  logic         done;
  logic         div_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_div #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a2       (a2),
    .b2       (b2),
    .quo      (quo),
    .rem      (rem),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] q, output logic [N-1:0] r,
                       output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Entered #1 after the accepting edge plus `pre` further edges.
  task automatic finish_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           input string tag, input int pre);
    logic [N-1:0] eq, er, hq, hr;
    logic         ez, hz;
    int           cyc;
    bit           bad_busy, moved;
    model(a, b, eq, er, ez);
    hq = quo;
    hr = rem;
    hz = div_zero;
    cyc = pre;
    bad_busy = 0;
    moved = 0;
    while (cyc < N + 4) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) bad_busy = 1;
      if ({quo, rem, div_zero} !== {hq, hr, hz}) moved = 1;
    end
    checks++;
    if (bad_busy) begin
      errors++;
      $display("FAIL %s busy: dropped before done, required 1", tag);
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL %s hold: outputs changed mid-run, required %h/%h/%b",
               tag, hq, hr, hz);
    end
    checks++;
    if (done !== 1'b1 || cyc != N) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d cycles, required 1 after %0d",
               tag, done, cyc, N);
    end
    checks++;
    if ({quo, rem, div_zero} !== {eq, er, ez}) begin
      errors++;
      $display("FAIL %s result: quo=%h rem=%h dz=%b, required %h %h %b",
               tag, quo, rem, div_zero, eq, er, ez);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_done: busy=%b with done, required 0", tag, busy);
    end
  endtask

  // Called #1 after an edge with the divider idle.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input string tag);
    start = 1'b1;
    a2 = a;
    b2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a2 = N'($urandom);
    b2 = N'($urandom);
    finish_op(a, b, tag, 0);
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: done=%b a cycle later, required 0", tag, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a2 = '0;
    b2 = '0;
    #12;
    checks++;
    if ({quo, rem, busy, done, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset: quo=%h rem=%h b/d/z=%b%b%b, required all 0",
               quo, rem, busy, done, div_zero);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(16'd100, 16'd7, "first_after_reset");
  endtask

  task automatic test_directed;
    logic [N-1:0] hq, hr;
    logic         hz;
    bit           moved;
    issue(16'hFFFF, 16'd1, "ffff_by_1");
    issue(16'd5, 16'd9, "5_by_9");
    issue(16'd0, 16'd3, "0_by_3");
    issue(16'hFFFF, 16'hFFFF, "max_by_max");
    hq = quo;
    hr = rem;
    hz = div_zero;
    moved = 0;
    repeat (5) begin
      a2 = N'($urandom);
      b2 = N'($urandom);
      @(posedge clk);
      #1;
      if ({quo, rem, div_zero, busy, done} !== {hq, hr, hz, 2'b00})
        moved = 1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL idle_hold: quo=%h rem=%h, required %h %h idle",
               quo, rem, hq, hr);
    end
  endtask

  task automatic test_div_zero;
    issue(16'h1234, 16'd0, "div_zero");
    issue(16'd10, 16'd3, "after_div_zero");
  endtask

  task automatic test_ignore_start;
    start = 1'b1;
    a2 = 16'd1000;
    b2 = 16'd33;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    a2 = 16'd7;
    b2 = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_op(16'd1000, 16'd33, "ignore_start", 5);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    bit stray;
    start = 1'b1;
    a2 = 16'd5000;
    b2 = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quo, rem, busy, done, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid: quo=%h rem=%h b/d/z=%b%b%b, required all 0",
               quo, rem, busy, done, div_zero);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 0;
    repeat (N + 4) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || quo !== '0) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_abort: done=%b busy=%b quo=%h, required 0 0 0",
               done, busy, quo);
    end
    issue(16'd999, 16'd10, "after_reset_mid");
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] a_1, b_1, a_2, b_2;
    int gap;
    a_1 = N'($urandom);
    b_1 = N'($urandom_range(1, 500));
    a_2 = N'($urandom);
    b_2 = N'($urandom_range(1, 500));
    start = 1'b1;
    a2 = a_1;
    b2 = b_1;
    @(posedge clk);
    #1;
    a2 = a_2;
    b2 = b_2;
    finish_op(a_1, b_1, "b2b_first", 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    a2 = N'($urandom);
    b2 = N'($urandom);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", done, busy);
    end
    gap = 1;
    while (gap < 40 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      gap++;
    end
    checks++;
    if (gap != N + 1) begin
      errors++;
      $display("FAIL b2b_gap: done pulses %0d apart, required %0d", gap, N + 1);
    end
    begin
      logic [N-1:0] eq, er;
      logic         ez;
      model(a_2, b_2, eq, er, ez);
      checks++;
      if ({quo, rem, div_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL b2b_second: quo=%h rem=%h dz=%b, required %h %h %b",
                 quo, rem, div_zero, eq, er, ez);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [N-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = N'($urandom_range(1, 15));
        2: b = N'($urandom_range(1, 255));
        default: b = N'($urandom);
      endcase
      if (b != 0) begin
        checks++;
        if (a != (a / b) * b + (a % b) || (a % b) >= b) begin
          errors++;
          $display("FAIL model_identity: a=%h b=%h", a, b);
        end
      end
      issue(a, b, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter N, default 16, giving the operand width in bits; legal range is 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port a2, input, N bits: unsigned dividend; sampled on the accepting edge.
REQ-006 SHALL have port b2, input, N bits: unsigned divisor; sampled on the accepting edge.
REQ-007 SHALL have port quo, output, N bits: quotient, registered.
REQ-008 SHALL have port rem, output, N bits: remainder, registered.
REQ-009 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking quo/rem/div_zero valid.
REQ-011 SHALL have port div_zero, output, 1 bit: high with done when b2 was 0; held like quo/rem.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN, plus an N-step counter of width clog2(N)+1.
REQ-013 SHALL, in IDLE with start=1 at edge k, capture a2 and b2, clear the partial remainder and counter, and enter RUN.
REQ-014 SHALL, in IDLE with start=0, hold state and all outputs.
REQ-015 SHALL perform one restoring step per RUN edge: shift {rem,dividend} left by 1, trial-subtract the divisor using N+1-bit arithmetic, keep the difference and set the quotient LSB to 1 if it is non-negative, else restore and set it to 0.
REQ-016 SHALL complete after exactly N RUN steps (edges k+1..k+N), return to IDLE at edge k+N, update quo/rem/div_zero, and drive done=1 for exactly the following cycle.
REQ-017 SHALL give a fixed latency of N cycles from the accepting edge to done, independent of operand values.
REQ-018 SHALL drive busy=1 exactly while the FSM is in RUN; busy and done are never high together.
REQ-019 SHALL ignore start while busy=1; operand inputs in RUN have no effect.
REQ-020 SHALL accept a new start during the done cycle, because the FSM is then in IDLE; done still pulses only once for the previous operation.
REQ-021 SHALL, when the captured divisor is 0, still take N cycles and then present quo = all ones, rem = the captured dividend, div_zero=1.
REQ-022 SHALL clear div_zero on the next completed non-zero division only.
REQ-023 SHALL hold quo, rem and div_zero stable from completion until the next completion or reset.
REQ-024 SHALL guarantee, for b2≠0, that a2 = quo*b2 + rem and rem < b2, unsigned.

Reset
REQ-025 SHALL, on rst_n low, immediately and regardless of clk, force IDLE, counter=0, quo=0, rem=0, busy=0, done=0, div_zero=0.
REQ-026 SHALL, on reset during RUN, abort the operation with no done pulse; the aborted result is never presented.
REQ-027 SHALL accept start on the first rising clk edge after rst_n deasserts.

Verification
REQ-028 SHALL pass with N=16, a2=100, b2=7, start at edge k: busy=1 for edges k+1..k+N, then done=1 with quo=14, rem=2, div_zero=0, exactly 16 cycles after acceptance.
REQ-029 SHALL pass with a2=0xFFFF, b2=1 giving quo=0xFFFF, rem=0, and with a2=5, b2=9 giving quo=0, rem=5.
REQ-030 SHALL pass with a2=0x1234, b2=0: done after 16 cycles with quo=0xFFFF, rem=0x1234, div_zero=1; a following 10/3 completes with quo=3, rem=1, div_zero=0.
REQ-031 SHALL pass with start pulsed at cycle 5 of RUN using different operands: no effect, and the original result is produced on schedule.
REQ-032 SHALL pass with rst_n asserted at cycle 8 of RUN: all outputs 0 immediately, no done pulse, and a new start after release completes normally.
REQ-033 SHALL pass with start held high during the done cycle: the second operation is accepted and back-to-back results appear with done pulses 17 cycles apart.
